// File: rtl/mdu_ctrl_if.sv
// ============================================================================
//  Module      : mdu_ctrl_if
//  Description : E-stage multiply/divide bus between the pipeline and the
//                MDU controller (operation issue, operands, stall, HI/LO).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mdu_ctrl_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       E_md_op;
    logic             E_md_valid;
    logic [WIDTH-1:0] E_rs;
    logic [WIDTH-1:0] E_rt;
    logic             E_mf_sel;
    logic             D_is_md;
    logic             busy;
    logic             stall_md;
    logic [WIDTH-1:0] E_md_rdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Pipeline side: issues operations and consumes status/read data
    modport master (
        output E_md_op, E_md_valid, E_rs, E_rt, E_mf_sel, D_is_md,
        input  busy, stall_md, E_md_rdata, hi, lo
    );

    // MDU side
    modport slave (
        input  E_md_op, E_md_valid, E_rs, E_rt, E_mf_sel, D_is_md,
        output busy, stall_md, E_md_rdata, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/mdu_ctrl.sv
// ============================================================================
//  Module      : mdu_ctrl
//  Description : E-stage multiply/divide controller. Computes MULT/MULTU/
//                DIV/DIVU results at issue, holds them for a fixed latency,
//                then commits them to HI/LO. Serves MTHI/MTLO and HI/LO
//                reads and raises the MD stall request for the hazard unit.
//  Options     : `define MDU_MADD_EN enables op 7 (madd, signed accumulate
//                into {HI,LO}); otherwise op 7 behaves as no operation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_ctrl #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic   clk,
    input  wire logic   reset,
    mdu_ctrl_if.slave   bus
);

    // Operation encodings on E_md_op
    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;
    localparam logic [2:0] c_OP_MADD  = 3'd7;

    // Controller states
    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    // Counter sized for the longer of the two latencies
    localparam int c_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CW      = $clog2(c_MAX_CYC + 1);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
    localparam logic [c_CW-1:0] c_MULT_LD = c_CW'(MULT_CYCLES);
    localparam logic [c_CW-1:0] c_DIV_LD  = c_CW'(DIV_CYCLES);

    logic [0:0]       r_state;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_res_hi;
    logic [WIDTH-1:0] r_res_lo;
    logic             r_res_wr;

    logic             w_is_madd;
    logic             w_start;
    logic             w_mthi;
    logic             w_mtlo;
    logic             w_rt_zero;
    logic [2*WIDTH-1:0] w_sprod;
    logic [2*WIDTH-1:0] w_uprod;
    logic signed [WIDTH-1:0] w_srs;
    logic signed [WIDTH-1:0] w_srt;
    logic [WIDTH-1:0] w_urt;
    logic [WIDTH-1:0] w_squo;
    logic [WIDTH-1:0] w_srem;
    logic [WIDTH-1:0] w_uquo;
    logic [WIDTH-1:0] w_urem;
    logic [2*WIDTH-1:0] w_acc;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;
    logic             w_res_wr;
    logic [c_CW-1:0]  w_lat;

`ifdef MDU_MADD_EN
    assign w_is_madd = (bus.E_md_op == c_OP_MADD);
    // Accumulates onto the HI/LO value present at issue
    assign w_acc     = {r_hi, r_lo} + w_sprod;
`else
    assign w_is_madd = 1'b0;
    assign w_acc     = '0;
`endif

    assign w_start = bus.E_md_valid &&
                     ((bus.E_md_op == c_OP_MULT) || (bus.E_md_op == c_OP_MULTU) ||
                      (bus.E_md_op == c_OP_DIV)  || (bus.E_md_op == c_OP_DIVU)  ||
                      w_is_madd);
    assign w_mthi  = bus.E_md_valid && (bus.E_md_op == c_OP_MTHI);
    assign w_mtlo  = bus.E_md_valid && (bus.E_md_op == c_OP_MTLO);

    // Sign-extended operands give the signed product in the low 2*WIDTH bits
    assign w_sprod = {{WIDTH{bus.E_rs[WIDTH-1]}}, bus.E_rs} *
                     {{WIDTH{bus.E_rt[WIDTH-1]}}, bus.E_rt};
    assign w_uprod = {{WIDTH{1'b0}}, bus.E_rs} * {{WIDTH{1'b0}}, bus.E_rt};

    // Divisor forced to 1 on zero so the divider never sees x/0; the result
    // is discarded in that case anyway
    assign w_rt_zero = (bus.E_rt == '0);
    assign w_urt     = w_rt_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : bus.E_rt;
    assign w_srs     = bus.E_rs;
    assign w_srt     = w_urt;
    assign w_squo    = w_srs / w_srt;
    assign w_srem    = w_srs % w_srt;
    assign w_uquo    = bus.E_rs / w_urt;
    assign w_urem    = bus.E_rs % w_urt;

    // Select the result, commit enable and latency for the issuing op
    always_comb begin
        w_res_hi = '0;
        w_res_lo = '0;
        w_res_wr = 1'b1;
        w_lat    = c_MULT_LD;
        case (bus.E_md_op)
            c_OP_MULT:  {w_res_hi, w_res_lo} = w_sprod;
            c_OP_MULTU: {w_res_hi, w_res_lo} = w_uprod;
            c_OP_DIV: begin
                w_res_hi = w_srem;
                w_res_lo = w_squo;
                w_res_wr = !w_rt_zero;
                w_lat    = c_DIV_LD;
            end
            c_OP_DIVU: begin
                w_res_hi = w_urem;
                w_res_lo = w_uquo;
                w_res_wr = !w_rt_zero;
                w_lat    = c_DIV_LD;
            end
            c_OP_MADD:  {w_res_hi, w_res_lo} = w_acc;
            default: ;
        endcase
    end

    // Sequencer: latch result at issue, count down, commit at the last cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_res_wr <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_start) begin
                        r_res_hi <= w_res_hi;
                        r_res_lo <= w_res_lo;
                        r_res_wr <= w_res_wr;
                        r_cnt    <= w_lat;
                        r_state  <= c_BUSY;
                    end else if (w_mthi) begin
                        r_hi <= bus.E_rs;
                    end else if (w_mtlo) begin
                        r_lo <= bus.E_rs;
                    end
                end
                c_BUSY: begin
                    // Starts and moves while busy are ignored
                    if (r_cnt == c_CNT_ONE) begin
                        if (r_res_wr) begin
                            r_hi <= r_res_hi;
                            r_lo <= r_res_lo;
                        end
                        r_cnt   <= '0;
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = (r_cnt != '0);
    assign bus.stall_md   = bus.D_is_md && (bus.busy || w_start);
    assign bus.E_md_rdata = bus.E_mf_sel ? r_hi : r_lo;
    assign bus.hi         = r_hi;
    assign bus.lo         = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// ============================================================================
//  Module      : tb_mdu_ctrl
//  Description : Directed self-checking bench for mdu_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mdu_ctrl_if #(.WIDTH(32)) bus ();

    mdu_ctrl #(
        .WIDTH       (32),
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present an op for one cycle; called and returns at #1 after a posedge
    task automatic issue(input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt);
        bus.E_md_op    = op;
        bus.E_md_valid = 1'b1;
        bus.E_rs       = rs;
        bus.E_rt       = rt;
        @(posedge clk);
        #1;
        bus.E_md_valid = 1'b0;
        bus.E_md_op    = 3'd0;
    endtask

    // Count cycles with busy high after issue (bounded) and check latency
    task automatic wait_done(input string tag, input int lat);
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_value(tag, 64'(n), 64'(lat));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b1;
        bus.E_md_op    = 3'd0;
        bus.E_md_valid = 1'b0;
        bus.E_rs       = '0;
        bus.E_rt       = '0;
        bus.E_mf_sel   = 1'b0;
        bus.D_is_md    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_hi",   64'(bus.hi), 64'h0);
        check_value("rst_lo",   64'(bus.lo), 64'h0);
        check_value("rst_busy", 64'(bus.busy), 64'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // mtlo while idle
        issue(3'd6, 32'h0000_1234, 32'h0);
        check_value("mtlo_lo",   64'(bus.lo), 64'h1234);
        check_value("mtlo_busy", 64'(bus.busy), 64'h0);

        // mult -3 * 5 with a D-stage MD op waiting
        bus.D_is_md    = 1'b1;
        bus.E_md_op    = 3'd1;
        bus.E_md_valid = 1'b1;
        bus.E_rs       = 32'hFFFF_FFFD;
        bus.E_rt       = 32'd5;
        #1;
        check_value("mult_stall_t0", 64'(bus.stall_md), 64'h1);
        @(posedge clk);
        #1;
        bus.E_md_valid = 1'b0;
        bus.E_md_op    = 3'd0;
        for (int k = 0; k < 5; k++) begin
            check_value($sformatf("mult_busy%0d", k), 64'(bus.busy), 64'h1);
            check_value($sformatf("mult_stall%0d", k), 64'(bus.stall_md), 64'h1);
            check_value($sformatf("mult_hi_hold%0d", k), 64'(bus.hi), 64'h0);
            @(posedge clk);
            #1;
        end
        check_value("mult_busy_end",  64'(bus.busy), 64'h0);
        check_value("mult_stall_end", 64'(bus.stall_md), 64'h0);
        check_value("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check_value("mult_lo", 64'(bus.lo), 64'hFFFF_FFF1);
        bus.E_mf_sel = 1'b1;
        #1;
        check_value("mfhi", 64'(bus.E_md_rdata), 64'hFFFF_FFFF);
        bus.E_mf_sel = 1'b0;
        #1;
        check_value("mflo", 64'(bus.E_md_rdata), 64'hFFFF_FFF1);
        bus.D_is_md = 1'b0;

        // multu 0xFFFFFFFF * 2
        issue(3'd2, 32'hFFFF_FFFF, 32'd2);
        wait_done("multu_lat", 5);
        check_value("multu_hi", 64'(bus.hi), 64'h1);
        check_value("multu_lo", 64'(bus.lo), 64'hFFFF_FFFE);

        // div -7 / 2
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_lat", 10);
        check_value("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check_value("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);

        // divu 100 / 7
        issue(3'd4, 32'd100, 32'd7);
        wait_done("divu_lat", 10);
        check_value("divu_hi", 64'(bus.hi), 64'd2);
        check_value("divu_lo", 64'(bus.lo), 64'd14);

        // divide by zero: full latency, HI/LO untouched
        issue(3'd3, 32'd55, 32'd0);
        wait_done("div0_lat", 10);
        check_value("div0_hi", 64'(bus.hi), 64'd2);
        check_value("div0_lo", 64'(bus.lo), 64'd14);

        // start while busy is ignored
        issue(3'd1, 32'd3, 32'd4);
        bus.E_md_op    = 3'd4;
        bus.E_md_valid = 1'b1;
        bus.E_rs       = 32'd100;
        bus.E_rt       = 32'd7;
        wait_done("sub_lat", 5);
        bus.E_md_valid = 1'b0;
        bus.E_md_op    = 3'd0;
        check_value("sub_hi", 64'(bus.hi), 64'h0);
        check_value("sub_lo", 64'(bus.lo), 64'd12);

`ifdef MDU_MADD_EN
        issue(3'd5, 32'h0, 32'h0);
        issue(3'd6, 32'hFFFF_FFFF, 32'h0);
        issue(3'd7, 32'd1, 32'd1);
        wait_done("madd_lat", 5);
        check_value("madd_hi", 64'(bus.hi), 64'h1);
        check_value("madd_lo", 64'(bus.lo), 64'h0);
`else
        issue(3'd5, 32'h55, 32'h0);
        check_value("mthi_hi", 64'(bus.hi), 64'h55);
        bus.D_is_md    = 1'b1;
        bus.E_md_op    = 3'd7;
        bus.E_md_valid = 1'b1;
        bus.E_rs       = 32'd1;
        bus.E_rt       = 32'd1;
        #1;
        check_value("op7_stall", 64'(bus.stall_md), 64'h0);
        @(posedge clk);
        #1;
        bus.E_md_valid = 1'b0;
        bus.E_md_op    = 3'd0;
        bus.D_is_md    = 1'b0;
        check_value("op7_busy", 64'(bus.busy), 64'h0);
        repeat (6) @(posedge clk);
        #1;
        check_value("op7_hi", 64'(bus.hi), 64'h55);
        check_value("op7_lo", 64'(bus.lo), 64'd12);
`endif

        // asynchronous reset in the middle of a divide (counter at 4)
        issue(3'd4, 32'd100, 32'd7);
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_value("arst_busy", 64'(bus.busy), 64'h0);
        check_value("arst_hi",   64'(bus.hi), 64'h0);
        check_value("arst_lo",   64'(bus.lo), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check_value("arst_hi_after",   64'(bus.hi), 64'h0);
        check_value("arst_lo_after",   64'(bus.lo), 64'h0);
        check_value("arst_busy_after", 64'(bus.busy), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
